// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: TinyRISC fetch front end with built-in IF/ID register.
// Generates the PC and fetches over a variable-latency req/ack memory port.
// A one-entry skid buffer holds a word that returns while decode is stalled.
// An EX-resolved redirect flushes IF/ID and the skid buffer. A request that is
// still in flight at redirect time is allowed to complete, and its data is dropped.
//
// Memory handshake: imem_req rises in FETCH/DROP and stays high, with imem_addr
// stable, until a cycle in which imem_ack=1. That cycle completes the transfer,
// and imem_rdata is taken in that same cycle. imem_ack is ignored while imem_req=0.
`timescale 1ns/1ps

module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h6800_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        isBranchTaken,
  input  logic [31:0] branchPC,
  input  logic        stall,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        valid_out,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DROP  = 2'd3;

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  logic [1:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] drop_addr, drop_addr_nxt;
  logic [31:0] skid_pc, skid_pc_nxt;
  logic [31:0] skid_instr, skid_instr_nxt;
  logic [31:0] pc_out_nxt, instr_out_nxt;
  logic        valid_out_nxt;

  logic [31:0] target;
  logic [31:0] pc_inc;
  logic        redirect;

  assign target   = branchPC & 32'hFFFF_FFFC;
  assign pc_inc   = pc + 32'd4;
  // BOOT has no request outstanding and ignores redirects.
  assign redirect = isBranchTaken && (state != ST_BOOT);

  // pc only ever holds word-aligned values, so it can be presented directly.
  // DROP keeps presenting the address of the abandoned request.
  assign imem_req  = (state == ST_FETCH) || (state == ST_DROP);
  assign imem_addr = (state == ST_DROP) ? drop_addr : pc;
  assign fsm_state = state;

  // Next-state and IF/ID/skid update; redirect outranks every other action.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    drop_addr_nxt  = drop_addr;
    skid_pc_nxt    = skid_pc;
    skid_instr_nxt = skid_instr;
    pc_out_nxt     = pc_out;
    instr_out_nxt  = instr_out;
    valid_out_nxt  = valid_out;

    case (state)
      ST_BOOT: begin
        state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        if (redirect) begin
          pc_nxt        = target;
          valid_out_nxt = 1'b0;
          instr_out_nxt = NOP_INSTR;
          if (imem_ack) begin
            // The returned word belongs to the wrong path; the next request goes to the target.
            state_nxt = ST_FETCH;
          end else begin
            drop_addr_nxt = pc;
            state_nxt     = ST_DROP;
          end
        end else if (imem_ack) begin
          pc_nxt = pc_inc;
          if (!stall || !valid_out) begin
            pc_out_nxt    = pc;
            instr_out_nxt = imem_rdata;
            valid_out_nxt = 1'b1;
          end else begin
            skid_pc_nxt    = pc;
            skid_instr_nxt = imem_rdata;
            state_nxt      = ST_HOLD;
          end
        end else if (!stall) begin
          valid_out_nxt = 1'b0;
          instr_out_nxt = NOP_INSTR;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          pc_nxt        = target;
          valid_out_nxt = 1'b0;
          instr_out_nxt = NOP_INSTR;
          state_nxt     = ST_FETCH;
        end else if (!stall) begin
          pc_out_nxt    = skid_pc;
          instr_out_nxt = skid_instr;
          valid_out_nxt = 1'b1;
          state_nxt     = ST_FETCH;
        end
      end

      ST_DROP: begin
        // IF/ID is already a bubble here; a repeated redirect only moves the target.
        if (redirect) pc_nxt = target;
        if (redirect || !stall) begin
          valid_out_nxt = 1'b0;
          instr_out_nxt = NOP_INSTR;
        end
        // The stale request completes on its ack. Its data is discarded, and fetch
        // resumes at the latest target.
        if (imem_ack) state_nxt = ST_FETCH;
      end

      default: begin
        state_nxt = ST_BOOT;
      end
    endcase
  end

  // State, PC, skid and IF/ID registers; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_BOOT;
      pc         <= RESET_PC_ALIGNED;
      drop_addr  <= RESET_PC_ALIGNED;
      skid_pc    <= 32'd0;
      skid_instr <= NOP_INSTR;
      pc_out     <= 32'd0;
      instr_out  <= NOP_INSTR;
      valid_out  <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      drop_addr  <= drop_addr_nxt;
      skid_pc    <= skid_pc_nxt;
      skid_instr <= skid_instr_nxt;
      pc_out     <= pc_out_nxt;
      instr_out  <= instr_out_nxt;
      valid_out  <= valid_out_nxt;
    end
  end

endmodule
